// File: rtl/slot_io_pkg.sv
// Shared definitions for the slot I/O responder: FSM encoding, register offsets,
// CTRL/STATUS field positions and the wait-counter width.
package slot_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int CNT_W = 5;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_DOORBELL = 2;
  localparam int REG_SCRATCH0 = 3;

  localparam int CTRL_WAIT_W     = 4;
  localparam int CTRL_IRQ_EN_BIT = 7;
  localparam int STATUS_PEND_BIT = 0;

  // Base plus programmed extra wait; both are 4-bit so the 5-bit sum cannot wrap.
  function automatic logic [CNT_W-1:0] total_wait(input logic [CTRL_WAIT_W-1:0] base,
                                                  input logic [CTRL_WAIT_W-1:0] extra);
    return CNT_W'(base) + CNT_W'(extra);
  endfunction

endpackage

// File: rtl/slot_io_responder_if.sv
// Dock I/O cycle signals between the address decoder (master) and a slot card (slave).
interface slot_io_responder_if #(
  parameter int ADDR_W = 8
);
  // Handshake: the master holds cs_n low with io_r_w_/addr/wdata stable; the slave holds
  // dev_ready_n low while it inserts wait states and raises it once the access is done.
  // The master samples dev_ready_n from one clk after asserting cs_n, and ends the cycle
  // by raising cs_n for at least one clk. rdata is meaningful only while rdata_oe is 1.
  logic              cs_n;
  logic              io_r_w_;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              rdata_oe;
  logic              dev_ready_n;
  logic              irq_n;

  modport master (
    output cs_n, io_r_w_, addr, wdata,
    input  rdata, rdata_oe, dev_ready_n, irq_n
  );

  modport slave (
    input  cs_n, io_r_w_, addr, wdata,
    output rdata, rdata_oe, dev_ready_n, irq_n
  );
endinterface

// File: rtl/slot_io_regfile.sv
// Register file of the slot responder: CTRL, STATUS, DOORBELL and scratch registers.
// Build with SLOT_IO_IRQ_EN to add the irq_pending flop behind STATUS/DOORBELL.
module slot_io_regfile
  import slot_io_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int OFF_W    = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [OFF_W-1:0]       wr_off,
  input  logic [7:0]             wr_data,
  input  logic [OFF_W-1:0]       rd_off,
  output logic [7:0]             rd_data,
  output logic [CTRL_WAIT_W-1:0] extra_wait,
  output logic                   irq_req
);

`ifdef SLOT_IO_IRQ_EN
  localparam logic [7:0] CTRL_MASK = 8'h8F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

  logic [7:0] ctrl_q;
  logic [7:0] scratch_q [REG_SCRATCH0:NUM_REGS-1];
  logic       pending;
  logic       wr_ctrl;
  logic       wr_scratch;

  assign wr_ctrl    = wr_en && (wr_off == OFF_W'(REG_CTRL));
  assign wr_scratch = wr_en && (int'(wr_off) >= REG_SCRATCH0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      for (int i = REG_SCRATCH0; i < NUM_REGS; i++) scratch_q[i] <= '0;
    end else begin
      if (wr_ctrl)    ctrl_q            <= wr_data & CTRL_MASK;
      if (wr_scratch) scratch_q[wr_off] <= wr_data;
    end
  end

`ifdef SLOT_IO_IRQ_EN
  logic wr_status;
  logic wr_doorbell;
  logic pending_q;

  assign wr_status   = wr_en && (wr_off == OFF_W'(REG_STATUS));
  assign wr_doorbell = wr_en && (wr_off == OFF_W'(REG_DOORBELL));

  // Doorbell set takes priority; both can never be requested on the same edge anyway.
  always_ff @(posedge clk) begin
    if (rst)                                           pending_q <= 1'b0;
    else if (wr_doorbell)                              pending_q <= 1'b1;
    else if (wr_status && wr_data[STATUS_PEND_BIT])    pending_q <= 1'b0;
  end

  assign pending = pending_q;
`else
  assign pending = 1'b0;
`endif

  assign irq_req    = ctrl_q[CTRL_IRQ_EN_BIT] & pending;
  assign extra_wait = ctrl_q[CTRL_WAIT_W-1:0];

  always_comb begin
    rd_data = '0;
    if (rd_off == OFF_W'(REG_CTRL))                rd_data = ctrl_q;
    else if (rd_off == OFF_W'(REG_STATUS))         rd_data = {7'b0, pending};
    else if (int'(rd_off) >= REG_SCRATCH0)         rd_data = scratch_q[rd_off];
  end

endmodule

// File: rtl/slot_io_responder.sv
// Slot-side target of the dock I/O cycle: captures a cycle on cs_n, inserts wait states,
// then acknowledges. Define SLOT_IO_IRQ_EN to enable the doorbell interrupt on irq_n.
module slot_io_responder
  import slot_io_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst,
  slot_io_responder_if.slave bus,
  output state_e             dbg_state
);

  localparam int OFF_W = $clog2(NUM_REGS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load_cnt;

  logic             rd_op_q;
  logic [OFF_W-1:0] off_q;
  logic [7:0]       wdata_q;

  logic             cur_rd;
  logic [OFF_W-1:0] cur_off;
  logic [7:0]       cur_wdata;

  logic             enter_ack;
  logic             capture;
  logic             ready_n_d, oe_d;

  logic [7:0]             reg_rd_data;
  logic [CTRL_WAIT_W-1:0] extra_wait;
  logic                   irq_req;

  logic       ready_n_q, oe_q, irq_n_q;
  logic [7:0] rdata_q;

  // A zero-wait cycle acks on the capture edge itself, so it uses the live bus values.
  assign cur_rd    = (state_q == ST_IDLE) ? bus.io_r_w_           : rd_op_q;
  assign cur_off   = (state_q == ST_IDLE) ? bus.addr[OFF_W-1:0]   : off_q;
  assign cur_wdata = (state_q == ST_IDLE) ? bus.wdata             : wdata_q;

  assign load_cnt = total_wait(CTRL_WAIT_W'(WAIT_STATES), extra_wait);
  assign capture  = (state_q == ST_IDLE) && !bus.cs_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    ready_n_d = 1'b1;
    oe_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.cs_n) begin
          if (load_cnt == '0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
            oe_d      = cur_rd;
          end else begin
            state_d   = ST_WAIT;
            cnt_d     = load_cnt;
            ready_n_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (bus.cs_n) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = ST_ACK;
          cnt_d     = '0;
          enter_ack = 1'b1;
          oe_d      = rd_op_q;
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          ready_n_d = 1'b0;
        end
      end
      ST_ACK: begin
        if (bus.cs_n) state_d = ST_IDLE;
        else          oe_d    = rd_op_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_op_q <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      rd_op_q <= bus.io_r_w_;
      off_q   <= bus.addr[OFF_W-1:0];
      wdata_q <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_n_q <= 1'b1;
      oe_q      <= 1'b0;
      rdata_q   <= '0;
      irq_n_q   <= 1'b1;
    end else begin
      ready_n_q <= ready_n_d;
      oe_q      <= oe_d;
      irq_n_q   <= ~irq_req;
      if (enter_ack && cur_rd) rdata_q <= reg_rd_data;
    end
  end

  slot_io_regfile #(
    .NUM_REGS (NUM_REGS),
    .OFF_W    (OFF_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (enter_ack && !cur_rd),
    .wr_off     (cur_off),
    .wr_data    (cur_wdata),
    .rd_off     (cur_off),
    .rd_data    (reg_rd_data),
    .extra_wait (extra_wait),
    .irq_req    (irq_req)
  );

  assign bus.dev_ready_n = ready_n_q;
  assign bus.rdata_oe    = oe_q;
  assign bus.rdata       = rdata_q;
  assign bus.irq_n       = irq_n_q;
  assign dbg_state       = state_q;

endmodule
